// File: rtl/prime_bus_master.sv
// prime_bus_master
//   Bus initiator for the gpioemu prime-number peripheral. A request carrying N
//   is accepted on a valid/ready port. N is written to the argument register.
//   The status register is then polled until it reports N. The result register
//   is read and returned as the N-th prime on a valid/ready response port.
//
// Ports
//   clk, n_reset            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_arg (10b) sampled on accept
//   resp_valid/resp_ready   response handshake; resp_data (32b), resp_err
//   busy                    high from accept until the response handshake
//   saddress/srd/swr        peripheral bus address and read/write strobes
//   sdata_out/sdata_in      peripheral write data / read data
module prime_bus_master #(
  parameter logic [15:0] A_ADDR        = 16'h0238,
  parameter logic [15:0] S_ADDR        = 16'h0250,
  parameter logic [15:0] W_ADDR        = 16'h0248,
  parameter int          STROBE_CYCLES = 2,
  parameter int          POLL_INTERVAL = 16,
  parameter int          TIMEOUT_POLLS = 1024
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_arg,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  localparam int PW = $clog2(TIMEOUT_POLLS + 1);
  localparam int WW = $clog2(POLL_INTERVAL + 1);
  localparam int SW = $clog2(STROBE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_A, ST_WAIT, ST_RD_S, ST_RD_W, ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP, PH_STROBE, PH_HOLD
  } phase_t;

  state_t        state_reg, state_next;
  phase_t        phase_reg, phase_next;
  logic [SW-1:0] strb_reg, strb_next;
  logic [WW-1:0] wait_reg, wait_next;
  logic [PW-1:0] poll_reg, poll_next;
  logic [9:0]    arg_reg, arg_next;
  logic [31:0]   last_s_reg, last_s_next;
  logic [31:0]   data_reg, data_next;
  logic          err_reg, err_next;

  logic          access_done;
  logic [PW-1:0] poll_inc;

  // State register (with the datapath registers that move alongside it).
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg  <= ST_IDLE;
      phase_reg  <= PH_SETUP;
      strb_reg   <= '0;
      wait_reg   <= '0;
      poll_reg   <= '0;
      arg_reg    <= '0;
      last_s_reg <= '0;
      data_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      strb_reg   <= strb_next;
      wait_reg   <= wait_next;
      poll_reg   <= poll_next;
      arg_reg    <= arg_next;
      last_s_reg <= last_s_next;
      data_reg   <= data_next;
      err_reg    <= err_next;
    end
  end

  // Poll counter saturates at the timeout value instead of wrapping.
  assign poll_inc = (poll_reg == PW'(TIMEOUT_POLLS)) ? poll_reg : poll_reg + PW'(1);

  // Next-state logic.
  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    strb_next   = strb_reg;
    wait_next   = wait_reg;
    poll_next   = poll_reg;
    arg_next    = arg_reg;
    last_s_next = last_s_reg;
    data_next   = data_reg;
    err_next    = err_reg;
    access_done = 1'b0;

    // Shared SETUP -> STROBE x N -> HOLD sequencer used by every bus access.
    if (state_reg inside {ST_WR_A, ST_RD_S, ST_RD_W}) begin
      case (phase_reg)
        PH_SETUP: begin
          phase_next = PH_STROBE;
          strb_next  = '0;
        end
        PH_STROBE: begin
          if (strb_reg == SW'(STROBE_CYCLES - 1)) phase_next = PH_HOLD;
          else                                    strb_next  = strb_reg + SW'(1);
        end
        default: begin
          phase_next  = PH_SETUP;
          access_done = 1'b1;   // read data is captured on this edge
        end
      endcase
    end

    case (state_reg)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          arg_next    = req_arg;
          poll_next   = '0;
          last_s_next = '0;
          wait_next   = '0;
          if (req_arg == 10'd0) begin
            state_next = ST_RESP;
            data_next  = '0;
            err_next   = 1'b1;
          end else begin
            state_next = ST_WR_A;
          end
        end
      end
      ST_WR_A: begin
        if (access_done) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_reg == WW'(POLL_INTERVAL - 1)) begin
          wait_next = '0;
          if (poll_reg == PW'(TIMEOUT_POLLS)) begin
            state_next = ST_RESP;
            data_next  = last_s_reg;
            err_next   = 1'b1;
          end else begin
            state_next = ST_RD_S;
          end
        end else begin
          wait_next = wait_reg + WW'(1);
        end
      end
      ST_RD_S: begin
        if (access_done) begin
          last_s_next = sdata_in;
          poll_next   = poll_inc;
          // Only the low 10 bits carry the count; S>N simply keeps polling.
          if (sdata_in[9:0] == arg_reg) begin
            if (poll_inc == PW'(TIMEOUT_POLLS)) begin
              state_next = ST_RESP;
              data_next  = sdata_in;
              err_next   = 1'b1;
            end else begin
              state_next = ST_RD_W;
            end
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_RD_W: begin
        if (access_done) begin
          poll_next = poll_inc;
          // W reads 0 until the peripheral commits it, a couple of clocks after S.
          if (sdata_in != 32'd0) begin
            state_next = ST_RESP;
            data_next  = sdata_in;
            err_next   = 1'b0;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decode straight from registers, so async reset drops strobes at once.
  always_comb begin
    saddress  = '0;
    sdata_out = '0;
    srd       = 1'b0;
    swr       = 1'b0;
    case (state_reg)
      ST_WR_A: begin
        saddress  = A_ADDR;
        sdata_out = {22'b0, arg_reg};
        swr       = (phase_reg == PH_STROBE);
      end
      ST_RD_S: begin
        saddress = S_ADDR;
        srd      = (phase_reg == PH_STROBE);
      end
      ST_RD_W: begin
        saddress = W_ADDR;
        srd      = (phase_reg == PH_STROBE);
      end
      default: ;
    endcase
    req_ready  = n_reset && (state_reg == ST_IDLE);
    resp_valid = (state_reg == ST_RESP);
    resp_data  = data_reg;
    resp_err   = err_reg;
    busy       = (state_reg != ST_IDLE);
  end

endmodule

// File: tb/tb_prime_bus_master.sv
// Bench for prime_bus_master. Two instances share clk/n_reset:
//   instance 0: STROBE_CYCLES=2, TIMEOUT_POLLS=1024, slow peripheral model
//   instance 1: STROBE_CYCLES=3, TIMEOUT_POLLS=4, fast peripheral model
// Each instance has a behavioural gpioemu model plus a bus protocol monitor.
module tb_prime_bus_master;

  logic              clk = 1'b0;
  logic              n_reset = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0][9:0]   req_arg = '0;
  logic [1:0]        resp_ready = '0;
  wire  [1:0]        req_ready;
  wire  [1:0]        resp_valid;
  wire  [1:0][31:0]  resp_data;
  wire  [1:0]        resp_err;
  wire  [1:0]        busy;
  wire  [1:0][15:0]  saddress;
  wire  [1:0]        srd;
  wire  [1:0]        swr;
  wire  [1:0][31:0]  sdata_out;

  int s_limit [2];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic int prime_of(input int n);
    int c;
    int p;
    bit isp;
    c = 0;
    p = 1;
    while (c < n) begin
      p++;
      isp = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 1'b0;
      if (isp) c++;
    end
    return p;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int SC     = (gi == 0) ? 2 : 3;
    localparam int TP     = (gi == 0) ? 1024 : 4;
    localparam int PERIOD = (gi == 0) ? 8 : 3;

    logic [31:0] per_rdata = '0;

    prime_bus_master #(
      .STROBE_CYCLES(SC),
      .POLL_INTERVAL(16),
      .TIMEOUT_POLLS(TP)
    ) dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_arg    (req_arg[gi]),
      .resp_valid (resp_valid[gi]),
      .resp_ready (resp_ready[gi]),
      .resp_data  (resp_data[gi]),
      .resp_err   (resp_err[gi]),
      .busy       (busy[gi]),
      .saddress   (saddress[gi]),
      .srd        (srd[gi]),
      .swr        (swr[gi]),
      .sdata_out  (sdata_out[gi]),
      .sdata_in   (per_rdata)
    );

    // gpioemu model: S counts up every PERIOD clocks (capped by s_limit);
    // W clears when S changes and shows prime(S) two clocks later.
    logic [9:0] pn = '0;
    int ps = 0, pw = 0, tick = 0, wlag = 0;
    logic srd_q = 1'b0, swr_q = 1'b0;
    // 0: S reads, 1: W reads, 2: writes, 3: last write data, 4: last write address
    int mon_cnt [0:4] = '{default: 0};

    always @(posedge clk) begin
      srd_q <= srd[gi];
      swr_q <= swr[gi];
      if (swr[gi] && !swr_q) begin
        mon_cnt[2] <= mon_cnt[2] + 1;
        mon_cnt[3] <= int'(sdata_out[gi]);
        mon_cnt[4] <= int'(saddress[gi]);
        if (saddress[gi] == 16'h0238) begin
          pn   <= sdata_out[gi][9:0];
          ps   <= 0;
          pw   <= 0;
          tick <= 0;
          wlag <= 0;
        end
      end else if (pn != 10'd0) begin
        if (ps < int'(pn) && ps < s_limit[gi]) begin
          if (tick == PERIOD - 1) begin
            tick <= 0;
            ps   <= ps + 1;
            pw   <= 0;
            wlag <= 2;
          end else begin
            tick <= tick + 1;
          end
        end
        if (wlag > 0) begin
          wlag <= wlag - 1;
          if (wlag == 1) pw <= prime_of(ps);
        end
      end
      if (srd[gi] && !srd_q) begin
        if (saddress[gi] == 16'h0250) begin
          per_rdata  <= 32'(ps);
          mon_cnt[0] <= mon_cnt[0] + 1;
        end else if (saddress[gi] == 16'h0248) begin
          per_rdata  <= 32'(pw);
          mon_cnt[1] <= mon_cnt[1] + 1;
        end else begin
          per_rdata  <= 32'hDEAD_BEEF;
        end
      end
    end

    // Protocol monitor, sampled mid-cycle.
    // 0: srd&&swr, 1: address/data moved around a strobe, 2: wrong strobe width
    int chk_cnt [0:2] = '{default: 0};
    logic pr_srd = 1'b0, pr_swr = 1'b0;
    logic [15:0] pr_addr = '0;
    logic [31:0] pr_data = '0;
    int width = 0;

    always @(negedge clk) begin
      logic st, pst, bad;
      st  = srd[gi] | swr[gi];
      pst = pr_srd | pr_swr;
      bad = 1'b0;
      // Covers the setup cycle (value one sample back) and the strobe cycles.
      if (st && (saddress[gi] != pr_addr || sdata_out[gi] != pr_data)) bad = 1'b1;
      if (st && pst && (srd[gi] != pr_srd)) bad = 1'b1;
      if (!st && pst && saddress[gi] != pr_addr) bad = 1'b1;
      if (srd[gi] && swr[gi]) chk_cnt[0] <= chk_cnt[0] + 1;
      if (bad) chk_cnt[1] <= chk_cnt[1] + 1;
      if (!st && pst && width != SC) chk_cnt[2] <= chk_cnt[2] + 1;
      width   <= st ? (pst ? width + 1 : 1) : 0;
      pr_srd  <= srd[gi];
      pr_swr  <= swr[gi];
      pr_addr <= saddress[gi];
      pr_data <= sdata_out[gi];
    end
  end

  function automatic int mon(input int k, input int idx);
    if (k == 0) return (idx < 5) ? g_inst[0].mon_cnt[idx] : g_inst[0].chk_cnt[idx - 5];
    return (idx < 5) ? g_inst[1].mon_cnt[idx] : g_inst[1].chk_cnt[idx - 5];
  endfunction

  task automatic transact(input int k, input logic [9:0] n, output logic ok,
                          output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    req_valid[k] = 1'b1;
    req_arg[k]   = n;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    ok = 1'b0;
    d  = '0;
    e  = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (resp_valid[k]) begin
        ok = 1'b1;
        d  = resp_data[k];
        e  = resp_err[k];
        break;
      end
    end
    @(posedge clk); #1;
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
    $display("txn inst=%0d N=%0d resp_ok=%0b data=%0d err=%0b", k, n, ok, d, e);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b want=00", req_ready); else passed++;
    total++; if (resp_valid !== 2'b00) $display("FAIL reset_resp_valid got=%b want=00", resp_valid); else passed++;
    total++; if ((srd | swr | busy) !== 2'b00) $display("FAIL reset_strobes_busy got=%b want=00", srd | swr | busy); else passed++;
    total++; if (resp_data !== 64'd0 || saddress !== 32'd0) $display("FAIL reset_data_addr got=%h/%h want=0", resp_data, saddress); else passed++;
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 2'b11) $display("FAIL post_reset_ready got=%b want=11", req_ready); else passed++;
  endtask

  task automatic test_n1();
    logic ok, e; logic [31:0] d; int w0;
    w0 = mon(0, 2);
    transact(0, 10'd1, ok, d, e);
    total++; if (ok !== 1'b1) $display("FAIL n1_resp_timeout got=%b want=1", ok); else passed++;
    total++; if (d !== 32'd2 || e !== 1'b0) $display("FAIL n1_result got=%0d/%b want=2/0", d, e); else passed++;
    total++; if (mon(0, 2) - w0 !== 1) $display("FAIL n1_write_count got=%0d want=1", mon(0, 2) - w0); else passed++;
    total++; if (mon(0, 4) !== 32'h238 || mon(0, 3) !== 1) $display("FAIL n1_write got=%h/%0d want=238/1", mon(0, 4), mon(0, 3)); else passed++;
  endtask

  task automatic test_n5();
    logic ok, e; logic [31:0] d; int s0, w0;
    s0 = mon(0, 0); w0 = mon(0, 1);
    transact(0, 10'd5, ok, d, e);
    total++; if (ok !== 1'b1 || d !== 32'h0000000B || e !== 1'b0) $display("FAIL n5_result got=%b/%0d/%b want=1/11/0", ok, d, e); else passed++;
    total++; if (mon(0, 0) - s0 < 2) $display("FAIL n5_s_polls got=%0d want>=2", mon(0, 0) - s0); else passed++;
    total++; if (mon(0, 1) - w0 !== 1) $display("FAIL n5_w_reads got=%0d want=1", mon(0, 1) - w0); else passed++;
  endtask

  task automatic test_n0_and_back_to_back();
    int r0, wr0;
    r0 = mon(0, 0) + mon(0, 1); wr0 = mon(0, 2);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_arg[0] = 10'd0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    total++; if (resp_valid[0] !== 1'b1 || busy[0] !== 1'b1) $display("FAIL n0_resp_next_clk got=%b/%b want=1/1", resp_valid[0], busy[0]); else passed++;
    total++; if (resp_data[0] !== 32'd0 || resp_err[0] !== 1'b1) $display("FAIL n0_result got=%0d/%b want=0/1", resp_data[0], resp_err[0]); else passed++;
    $display("txn inst=0 N=0 data=%0d err=%0b", resp_data[0], resp_err[0]);
    @(posedge clk); #1;
    resp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_arg[0] = 10'd0;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    total++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) $display("FAIL b2b_not_accepted got=%b/%b want=0/1", resp_valid[0], req_ready[0]); else passed++;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    total++; if (resp_valid[0] !== 1'b1) $display("FAIL b2b_accept_next got=%b want=1", resp_valid[0]); else passed++;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    total++; if (mon(0, 0) + mon(0, 1) - r0 !== 0 || mon(0, 2) - wr0 !== 0) $display("FAIL n0_bus_traffic got=%0d want=0", mon(0, 0) + mon(0, 1) + mon(0, 2) - r0 - wr0); else passed++;
  endtask

  task automatic test_timeout();
    logic ok, e; logic [31:0] d; int s0, w0;
    s_limit[1] = 3;
    s0 = mon(1, 0); w0 = mon(1, 1);
    transact(1, 10'd7, ok, d, e);
    total++; if (ok !== 1'b1 || e !== 1'b1 || d !== 32'd3) $display("FAIL timeout_result got=%b/%b/%0d want=1/1/3", ok, e, d); else passed++;
    total++; if (mon(1, 0) - s0 !== 4 || mon(1, 1) - w0 !== 0) $display("FAIL timeout_reads got=%0d/%0d want=4/0", mon(1, 0) - s0, mon(1, 1) - w0); else passed++;
    s_limit[1] = 1000;
  endtask

  task automatic test_protocol();
    logic ok, e; logic [31:0] d;
    transact(1, 10'd2, ok, d, e);
    total++; if (ok !== 1'b1 || d !== 32'd3 || e !== 1'b0) $display("FAIL proto_result got=%b/%0d/%b want=1/3/0", ok, d, e); else passed++;
    for (int k = 0; k < 2; k++) begin
      total++; if (mon(k, 5) !== 0) $display("FAIL proto_both_strobes inst=%0d got=%0d want=0", k, mon(k, 5)); else passed++;
      total++; if (mon(k, 6) !== 0) $display("FAIL proto_stability inst=%0d got=%0d want=0", k, mon(k, 6)); else passed++;
      total++; if (mon(k, 7) !== 0) $display("FAIL proto_strobe_width inst=%0d got=%0d want=0", k, mon(k, 7)); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic ok, e, seen; logic [31:0] d;
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_arg[0] = 10'd9;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      if (srd[0]) begin seen = 1'b1; break; end
    end
    total++; if (seen !== 1'b1) $display("FAIL midreset_no_srd got=0 want=1"); else passed++;
    #2;
    n_reset = 1'b0;
    #1;
    total++; if (srd[0] !== 1'b0 || busy[0] !== 1'b0) $display("FAIL midreset_async_drop got=%b/%b want=0/0", srd[0], busy[0]); else passed++;
    total++; if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0) $display("FAIL midreset_outputs got=%b/%b want=0/0", req_ready[0], resp_valid[0]); else passed++;
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(negedge clk);
    total++; if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) $display("FAIL midreset_release got=%b/%b want=1/0", req_ready[0], resp_valid[0]); else passed++;
    transact(0, 10'd2, ok, d, e);
    total++; if (ok !== 1'b1 || d !== 32'd3 || e !== 1'b0) $display("FAIL midreset_n2 got=%b/%0d/%b want=1/3/0", ok, d, e); else passed++;
  endtask

  initial begin
    s_limit[0] = 1000;
    s_limit[1] = 1000;
    test_reset();
    test_n1();
    test_n5();
    test_n0_and_back_to_back();
    test_timeout();
    test_protocol();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
